branch_unit: RTL and testbench
==============================

# branch_unit

Branch resolution and fetch-PC unit for the FPGA RISC V core. It consumes the `beq`/`blt` flags from the branch comparator and drives that comparator's `un` select. It evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR for the instruction in EX and owns the fetch PC register. On a taken redirect it loads the target PC and issues a multi-cycle flush to kill wrong-path instructions.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC value after reset
- FLUSH_CYCLES, 2, number of cycles `flush` stays high per redirect (legal range 1–15)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze: PC, flush counter and outputs hold; EX instruction not evaluated
- valid  in  1  EX stage holds a real instruction
- br  in  1  EX instruction is a conditional branch
- jal  in  1  EX instruction is JAL
- jalr  in  1  EX instruction is JALR
- funct3  in  3  branch funct3 from EX instruction
- pc_ex  in  32  PC of EX instruction
- imm  in  32  sign-extended immediate of EX instruction
- rs1  in  32  rs1 operand (JALR base)
- beq  in  1  comparator: rs1 == rs2
- blt  in  1  comparator: rs1 < rs2 under `br_un`
- br_un  out  1  comparator unsigned select, combinational = funct3[1]
- pc  out  32  fetch PC register
- flush  out  1  kill IF/ID and ID/EX contents
- taken  out  1  one-cycle pulse: redirect performed
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned
- taken_count  out  32  count of performed redirects

## Operation
- Evaluation enable `ev` = valid & ~stall & (fcnt == 0); instructions arriving during a flush window are wrong-path and ignored.
- Condition, with `br`: 000 → beq; 001 → ~beq; 100 → blt; 101 → ~blt; 110 → blt; 111 → ~blt; 010/011 → not taken (no redirect, no pulse).
- `req` = ev & (jal | jalr | (br & cond)). Priority when several type bits are set: jalr > jal > br.
- Target: JAL/branch = pc_ex + imm; JALR = (rs1 + imm) & ~32'h1. All 32-bit wrap-around addition, overflow ignored.
- If `req` and target[1:0] != 0: no redirect; `misalign` pulses; PC advances normally; count unchanged; no flush.
- If `req` and aligned: PC loads target; `taken` pulses; `taken_count` increments (wraps 2^32−1 → 0); flush counter `fcnt` loads FLUSH_CYCLES.
- Otherwise, when ~stall: PC ← PC + 4 (wraps at 2^32); `fcnt` decrements if nonzero.
- When stall: every register holds, including `fcnt` and `flush`. Pulses are cleared, so `taken`/`misalign` last exactly one unstalled cycle.
- `flush` = (fcnt != 0), registered.
- States: RUN (fcnt == 0) and FLUSH (fcnt > 0).
  - RUN → FLUSH on an aligned `req`.
  - FLUSH → RUN when fcnt reaches 0.
  - A redirect cannot occur in FLUSH, because `ev` = 0 there.
- Reset values: pc = RESET_PC, flush = 0, taken = 0, misalign = 0, taken_count = 0, fcnt = 0. Reset overrides stall and in-progress flush.

## Timing
- Decision is combinational in cycle N from the EX inputs and comparator flags. `pc`, `taken`, `misalign` and `flush` update at edge N+1.
- `flush` is high for cycles N+1 … N+FLUSH_CYCLES, assuming no stall. Each stall cycle extends the window by one.
- Redirect latency is 1 cycle: the target is fetched in cycle N+1.
- `br_un` has zero latency; the comparator flags are valid within the same cycle.
- Reset asserted in the same cycle as a `req` wins: pc = RESET_PC next cycle, no pulse, no count.

## Test plan
- Reset check: rst=1 for 2 cycles, RESET_PC=32'h100. Release rst with valid=0. Required: pc = 0x100, 0x104, 0x108; flush = taken = 0; taken_count = 0.
- BLTU/BGE signedness: funct3=110 → br_un=1, then funct3=101 → br_un=0. Drive blt=1, beq=0, pc_ex=0x40, imm=0x20. Required for BLTU: pc=0x60 next cycle; taken pulse; flush high 2 cycles; count=1. Required for BGE: no redirect, pc+4.
- JALR alignment: rs1=0x1001, imm=0x0 → target 0x1000, redirect. Then rs1=0x1002, imm=0 → misalign pulses once, no flush, count unchanged, pc advances +4.
- Flush shadow: a taken BEQ is followed by valid=1, jal=1 on the next two cycles. Required: both JALs ignored; third-cycle JAL redirects; count=2.
- Stall in flush window: redirect, then stall=1 for 3 cycles at N+1. Required: pc holds the target; flush stays high until 2 unstalled cycles have elapsed; taken pulses once.
- Counter wrap and reset mid-flush: preload taken_count near 2^32−1 via 1 redirect from 0xFFFF_FFFF state (bench force). Required: count wraps to 0. rst during FLUSH → flush=0 next cycle.

Source files
------------

// File: rtl/branch_unit.sv
// Branch resolution and fetch-PC unit: evaluates the EX-stage control transfer,
// owns the fetch PC and raises a multi-cycle flush after each taken redirect.
module branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid,
  input  logic        br,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        beq,
  input  logic        blt,
  output logic        br_un,
  output logic [31:0] pc,
  output logic        flush,
  output logic        taken,
  output logic        misalign,
  output logic [31:0] taken_count
);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_r, state_nx_s;
  logic [3:0]  fcnt_r, fcnt_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [31:0] count_r, count_nx_s;
  logic        flush_r, taken_r, taken_nx_s, misalign_r, misalign_nx_s;
  logic [31:0] target_s;
  logic        ev_s, req_s, aligned_s;

  function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt);
    logic c;
    case (f3)
      3'b000:         c = eq;
      3'b001:         c = ~eq;
      3'b100, 3'b110: c = lt;
      3'b101, 3'b111: c = ~lt;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

  assign br_un       = funct3[1];
  assign pc          = pc_r;
  assign flush       = flush_r;
  assign taken       = taken_r;
  assign misalign    = misalign_r;
  assign taken_count = count_r;

  // Redirect target; JALR clears bit 0 of the computed address.
  always_comb begin
    target_s = 32'h0000_0000;
    if (jalr) begin
      target_s = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = pc_ex + imm;
    end
  end

  // Instructions seen while the flush counter runs are wrong-path.
  assign ev_s      = valid & ~stall & (fcnt_r == 4'd0);
  assign req_s     = ev_s & (jalr | jal | (br & branch_cond(funct3, beq, blt)));
  assign aligned_s = (target_s[1:0] == 2'b00);

  // Next-state and next-output logic for the RUN/FLUSH controller.
  always_comb begin
    state_nx_s    = state_r;
    fcnt_nx_s     = fcnt_r;
    pc_nx_s       = pc_r;
    count_nx_s    = count_r;
    taken_nx_s    = 1'b0;
    misalign_nx_s = 1'b0;
    case (state_r)
      RUN: begin
        if (stall) begin
          state_nx_s = RUN;
        end else if (req_s && aligned_s) begin
          state_nx_s = FLUSH;
          fcnt_nx_s  = FLUSH_LOAD;
          pc_nx_s    = target_s;
          count_nx_s = count_r + 32'd1;
          taken_nx_s = 1'b1;
        end else begin
          pc_nx_s       = pc_r + 32'd4;
          misalign_nx_s = req_s;
        end
      end
      FLUSH: begin
        if (stall) begin
          state_nx_s = FLUSH;
        end else begin
          pc_nx_s    = pc_r + 32'd4;
          fcnt_nx_s  = fcnt_r - 4'd1;
          state_nx_s = (fcnt_r == 4'd1) ? RUN : FLUSH;
        end
      end
      default: begin
        state_nx_s = RUN;
        fcnt_nx_s  = 4'd0;
      end
    endcase
  end

  // State, PC, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      fcnt_r     <= 4'd0;
      pc_r       <= RESET_PC;
      count_r    <= 32'd0;
      flush_r    <= 1'b0;
      taken_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      fcnt_r     <= fcnt_nx_s;
      pc_r       <= pc_nx_s;
      count_r    <= count_nx_s;
      flush_r    <= (fcnt_nx_s != 4'd0);
      taken_r    <= taken_nx_s;
      misalign_r <= misalign_nx_s;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          FC     = 2;

  logic        clk, rst, stall, valid, br, jal, jalr, beq, blt;
  logic [2:0]  funct3;
  logic [31:0] pc_ex, imm, rs1;
  logic        br_un, flush, taken, misalign;
  logic [31:0] pc, taken_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_cnt;
  int          m_fl;
  logic        m_taken, m_mis;

  branch_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid(valid), .br(br), .jal(jal),
    .jalr(jalr), .funct3(funct3), .pc_ex(pc_ex), .imm(imm), .rs1(rs1),
    .beq(beq), .blt(blt), .br_un(br_un), .pc(pc), .flush(flush),
    .taken(taken), .misalign(misalign), .taken_count(taken_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall, valid, br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc_ex, imm, rs1;
    logic        beq, blt;
    logic [31:0] e_pc;
    logic        e_taken, e_mis, e_flush, e_un;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic spec_cond(input logic [2:0] f3, input logic eq, input logic lt);
    if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
    if (f3[2]) return f3[0] ? !lt : lt;
    return f3[0] ? !eq : eq;
  endfunction

  task automatic model_step();
    logic [31:0] tgt;
    logic        want;
    m_taken = 1'b0;
    m_mis   = 1'b0;
    if (rst) begin
      m_pc = RST_PC; m_cnt = 32'd0; m_fl = 0;
    end else if (!stall) begin
      want = valid && (m_fl == 0) && (jalr || jal || (br && spec_cond(funct3, beq, blt)));
      tgt  = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc_ex + imm);
      if (want && (tgt % 4 == 0)) begin
        m_pc = tgt; m_taken = 1'b1; m_cnt = m_cnt + 32'd1; m_fl = FC;
      end else begin
        m_pc = m_pc + 32'd4;
        m_mis = want;
        if (m_fl > 0) m_fl--;
      end
    end
  endtask

  // One clock: checks br_un, advances the model, compares all registered outputs.
  task automatic cyc();
    #1;
    chk("br_un", {31'b0, br_un}, {31'b0, funct3[1]});
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("flush", {31'b0, flush}, {31'b0, (m_fl > 0)});
    chk("taken", {31'b0, taken}, {31'b0, m_taken});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("count", taken_count, m_cnt);
  endtask

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; valid = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
    funct3 = 3'b000; pc_ex = 32'h0; imm = 32'h0; rs1 = 32'h0; beq = 1'b0; blt = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // stall valid br jal jalr f3 pc_ex imm rs1 beq blt | pc taken mis flush un
    vt[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,32'h40,32'h20,32'h0,1'b1,1'b0, 32'h60, 1'b1,1'b0,1'b1,1'b0};
    vt[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,32'h40,32'h20,32'h0,1'b0,1'b0, 32'h104,1'b0,1'b0,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b001,32'h40,32'h20,32'h0,1'b0,1'b0, 32'h60, 1'b1,1'b0,1'b1,1'b0};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b100,32'h40,32'h20,32'h0,1'b0,1'b1, 32'h60, 1'b1,1'b0,1'b1,1'b0};
    vt[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b101,32'h40,32'h20,32'h0,1'b0,1'b1, 32'h104,1'b0,1'b0,1'b0,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b110,32'h40,32'h20,32'h0,1'b0,1'b1, 32'h60, 1'b1,1'b0,1'b1,1'b1};
    vt[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b111,32'h40,32'h20,32'h0,1'b0,1'b0, 32'h60, 1'b1,1'b0,1'b1,1'b1};
    vt[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b010,32'h40,32'h20,32'h0,1'b1,1'b1, 32'h104,1'b0,1'b0,1'b0,1'b1};
    vt[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,32'h200,32'hFFFF_FFF0,32'h0,1'b0,1'b0, 32'h1F0,1'b1,1'b0,1'b1,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'b000,32'h40,32'h0,32'h1001,1'b0,1'b0, 32'h1000,1'b1,1'b0,1'b1,1'b0};
    vt[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'b000,32'h40,32'h0,32'h1002,1'b0,1'b0, 32'h104,1'b0,1'b1,1'b0,1'b0};
    vt[11] = '{1'b0,1'b1,1'b0,1'b1,1'b1,3'b000,32'h40,32'h4,32'h3000,1'b0,1'b0, 32'h3004,1'b1,1'b0,1'b1,1'b0};
    vt[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,32'h40,32'h22,32'h0,1'b1,1'b0, 32'h104,1'b0,1'b1,1'b0,1'b0};
    vt[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,32'h40,32'h20,32'h0,1'b0,1'b0, 32'h104,1'b0,1'b0,1'b0,1'b0};
    vt[14] = '{1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,32'h40,32'h20,32'h0,1'b0,1'b0, 32'h100,1'b0,1'b0,1'b0,1'b0};
    vt[15] = '{1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,32'hFFFF_FFF0,32'h20,32'h0,1'b0,1'b0, 32'h10,1'b1,1'b0,1'b1,1'b0};
    vt[16] = '{1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,32'h40,32'h8,32'h0,1'b0,1'b0, 32'h48,1'b1,1'b0,1'b1,1'b0};

    // Reset behaviour and free-running PC
    set_idle();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_pc", pc, 32'h100);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_taken", {31'b0, taken}, 32'd0);
    chk("rst_count", taken_count, 32'd0);
    rst = 1'b0;
    cyc();
    chk("run_pc1", pc, 32'h104);
    cyc();
    chk("run_pc2", pc, 32'h108);

    // Single-decision vectors, each from a fresh reset
    for (int i = 0; i < 17; i++) begin
      do_reset();
      stall = vt[i].stall; valid = vt[i].valid; br = vt[i].br; jal = vt[i].jal;
      jalr = vt[i].jalr; funct3 = vt[i].f3; pc_ex = vt[i].pc_ex; imm = vt[i].imm;
      rs1 = vt[i].rs1; beq = vt[i].beq; blt = vt[i].blt;
      #1;
      chk($sformatf("v%0d_br_un", i), {31'b0, br_un}, {31'b0, vt[i].e_un});
      cyc();
      chk($sformatf("v%0d_pc", i), pc, vt[i].e_pc);
      chk($sformatf("v%0d_taken", i), {31'b0, taken}, {31'b0, vt[i].e_taken});
      chk($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vt[i].e_mis});
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vt[i].e_flush});
      chk($sformatf("v%0d_count", i), taken_count, {31'b0, vt[i].e_taken});
    end

    // Flush shadow: two JALs in the window are ignored, the third redirects
    do_reset();
    valid = 1'b1; br = 1'b1; funct3 = 3'b000; beq = 1'b1; pc_ex = 32'h40; imm = 32'h20;
    cyc();
    chk("sh_pc0", pc, 32'h60);
    br = 1'b0; jal = 1'b1; pc_ex = 32'h80; imm = 32'h100;
    cyc();
    chk("sh_pc1", pc, 32'h64);
    chk("sh_flush1", {31'b0, flush}, 32'd1);
    cyc();
    chk("sh_pc2", pc, 32'h68);
    chk("sh_flush2", {31'b0, flush}, 32'd0);
    cyc();
    chk("sh_pc3", pc, 32'h180);
    chk("sh_taken3", {31'b0, taken}, 32'd1);
    chk("sh_count", taken_count, 32'd2);

    // Stall inside the flush window stretches it
    do_reset();
    valid = 1'b1; jal = 1'b1; pc_ex = 32'h40; imm = 32'h20;
    cyc();
    chk("st_pc0", pc, 32'h60);
    set_idle();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("st_hold_pc", pc, 32'h60);
      chk("st_hold_flush", {31'b0, flush}, 32'd1);
      chk("st_hold_taken", {31'b0, taken}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk("st_pc1", pc, 32'h64);
    chk("st_flush1", {31'b0, flush}, 32'd1);
    cyc();
    chk("st_pc2", pc, 32'h68);
    chk("st_flush2", {31'b0, flush}, 32'd0);
    chk("st_count", taken_count, 32'd1);

    // Reset wins over a simultaneous request
    set_idle();
    valid = 1'b1; jal = 1'b1; pc_ex = 32'h40; imm = 32'h20; rst = 1'b1;
    cyc();
    chk("rr_pc", pc, 32'h100);
    chk("rr_taken", {31'b0, taken}, 32'd0);
    chk("rr_count", taken_count, 32'd0);

    // Counter wrap from a forced all-ones count, then reset mid-flush
    do_reset();
    stall = 1'b1;
    force dut.count_r = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cyc();
    release dut.count_r;
    cyc();
    chk("wr_pre", taken_count, 32'hFFFF_FFFF);
    stall = 1'b0; valid = 1'b1; jal = 1'b1; pc_ex = 32'h40; imm = 32'h10;
    cyc();
    chk("wr_count", taken_count, 32'd0);
    chk("wr_flush", {31'b0, flush}, 32'd1);
    set_idle();
    rst = 1'b1;
    cyc();
    chk("rf_flush", {31'b0, flush}, 32'd0);
    chk("rf_pc", pc, 32'h100);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 59) == 0);
      stall  = ($urandom_range(0, 6) == 0);
      valid  = ($urandom_range(0, 3) != 0);
      br     = $urandom_range(0, 1) == 1;
      jal    = ($urandom_range(0, 4) == 0);
      jalr   = ($urandom_range(0, 5) == 0);
      funct3 = 3'($urandom_range(0, 7));
      pc_ex  = {$urandom} & 32'hFFFF_FFFC;
      imm    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255))
                                           : 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      rs1    = $urandom;
      beq    = $urandom_range(0, 1) == 1;
      blt    = $urandom_range(0, 1) == 1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
